// File: rtl/ps2_key_matrix_if.sv
// Byte-decoder, map-ROM and CPU-scan signals of the PS/2 key matrix engine.
// The slave modport is the matrix engine; master is whatever drives it.
interface ps2_key_matrix_if #(
    parameter int ROWS = 14,
    parameter int COLS = 7
);
    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);

    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_error;
    logic             map_req;
    logic [8:0]       map_code;
    logic [ROW_W-1:0] map_row;
    logic [COL_W-1:0] map_col;
    logic             map_hit;
    logic [ROWS-1:0]  ka;
    logic [COLS-1:0]  kd;
    logic             key_reset;
    logic             overrun;

    modport slave (
        input  rx_data, rx_valid, rx_error, map_row, map_col, map_hit, ka,
        output map_req, map_code, kd, key_reset, overrun
    );

    modport master (
        output rx_data, rx_valid, rx_error, map_row, map_col, map_hit, ka,
        input  map_req, map_code, kd, key_reset, overrun
    );
endinterface

// File: rtl/ps2_key_matrix.sv
// PS/2 scancode to ROWS x COLS key matrix: prefix tracking, map-ROM lookup,
// active-low CPU scan port and a stretched reset request on PAUSE/BREAK.
module ps2_key_matrix #(
    parameter int ROWS       = 14,
    parameter int COLS       = 7,
    parameter int RST_CYCLES = 16,
    parameter int CLR_ON_ERR = 1
) (
    input  logic                clk,
    input  logic                reset,
    ps2_key_matrix_if.slave     bus
);
    localparam int CNT_W = $clog2(RST_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, LOOK, APPLY, PAUSE} state_t;

    state_t                     state_q, state_d;
    logic                       ext_q, ext_d;
    logic                       rel_q, rel_d;
    logic [2:0]                 idx_q, idx_d;
    logic [ROWS-1:0][COLS-1:0]  pressed_q, pressed_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       map_req_q, map_req_d;
    logic [8:0]                 map_code_q, map_code_d;
    logic                       overrun_q, overrun_d;
    logic [COLS-1:0]            kd;

    // Bytes following E1 in the PAUSE/BREAK make sequence.
    function automatic logic [7:0] pause_byte(input logic [2:0] i);
        case (i)
            3'd0:    return 8'h14;
            3'd1:    return 8'h77;
            3'd2:    return 8'hE1;
            3'd3:    return 8'hF0;
            3'd4:    return 8'h14;
            3'd5:    return 8'hF0;
            default: return 8'h77;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        ext_d      = ext_q;
        rel_d      = rel_q;
        idx_d      = idx_q;
        pressed_d  = pressed_q;
        map_req_d  = 1'b0;
        map_code_d = map_code_q;
        overrun_d  = 1'b0;
        cnt_d      = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;

        if (bus.rx_error) begin
            state_d = IDLE;
            ext_d   = 1'b0;
            rel_d   = 1'b0;
            idx_d   = '0;
            if (CLR_ON_ERR != 0) pressed_d = '0;
        end else begin
            case (state_q)
                IDLE: if (bus.rx_valid) begin
                    case (bus.rx_data)
                        8'hE0: ext_d = 1'b1;
                        8'hF0: rel_d = 1'b1;
                        8'hE1: begin
                            state_d = PAUSE;
                            idx_d   = '0;
                            ext_d   = 1'b0;
                            rel_d   = 1'b0;
                        end
                        8'h00, 8'hFF: begin
                            ext_d = 1'b0;
                            rel_d = 1'b0;
                        end
                        default: begin
                            // A prefixed AA is an ordinary key code, not a BAT result.
                            if (bus.rx_data == 8'hAA && !ext_q && !rel_q) begin
                                pressed_d = '0;
                            end else begin
                                map_req_d  = 1'b1;
                                map_code_d = {ext_q, bus.rx_data};
                                state_d    = LOOK;
                            end
                        end
                    endcase
                end
                LOOK: begin
                    overrun_d = bus.rx_valid;
                    state_d   = APPLY;
                end
                APPLY: begin
                    overrun_d = bus.rx_valid;
                    // Loop bounds reject out-of-range ROM coordinates.
                    for (int r = 0; r < ROWS; r++)
                        for (int c = 0; c < COLS; c++)
                            if (bus.map_hit && int'(bus.map_row) == r && int'(bus.map_col) == c)
                                pressed_d[r][c] = ~rel_q;
                    ext_d   = 1'b0;
                    rel_d   = 1'b0;
                    state_d = IDLE;
                end
                PAUSE: if (bus.rx_valid) begin
                    if (bus.rx_data == pause_byte(idx_q)) begin
                        if (idx_q == 3'd6) begin
                            cnt_d   = CNT_W'(RST_CYCLES);
                            state_d = IDLE;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ext_q      <= 1'b0;
            rel_q      <= 1'b0;
            idx_q      <= '0;
            pressed_q  <= '0;
            cnt_q      <= '0;
            map_req_q  <= 1'b0;
            map_code_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ext_q      <= ext_d;
            rel_q      <= rel_d;
            idx_q      <= idx_d;
            pressed_q  <= pressed_d;
            cnt_q      <= cnt_d;
            map_req_q  <= map_req_d;
            map_code_q <= map_code_d;
            overrun_q  <= overrun_d;
        end
    end

    // Selected rows wire-AND onto the active-low column lines.
    always_comb begin
        kd = '1;
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                if (!bus.ka[r] && pressed_q[r][c]) kd[c] = 1'b0;
    end

    assign bus.kd        = kd;
    assign bus.map_req   = map_req_q;
    assign bus.map_code  = map_code_q;
    assign bus.key_reset = (cnt_q != '0);
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_ps2_key_matrix.sv
// Drives two matrix engines (CLR_ON_ERR=1 and 0) with one byte stream and
// checks them against a key-event level model of the matrix.
module tb_ps2_key_matrix;
    localparam int ROWS = 14;
    localparam int COLS = 7;
    localparam int RSTC = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [7:0]      rx_data;
    logic            rx_valid;
    logic            rx_error;
    logic [ROWS-1:0] ka;

    always #5 clk = ~clk;

    ps2_key_matrix_if #(.ROWS(ROWS), .COLS(COLS)) if0 ();
    ps2_key_matrix_if #(.ROWS(ROWS), .COLS(COLS)) if1 ();

    // ROM contents: {hit, row[3:0], col[2:0]}; default entries include out-of-range cells.
    function automatic logic [7:0] rom_fn(input logic [8:0] code);
        case (code)
            9'h01C:  return {1'b1, 4'd1,  3'd5};
            9'h015:  return {1'b1, 4'd0,  3'd6};
            9'h175:  return {1'b1, 4'd11, 3'd3};
            9'h033:  return {1'b1, 4'd2,  3'd2};
            default: return {code[2:0] != 3'd0, code[3:0], code[6:4]};
        endcase
    endfunction

    logic [7:0] rom0_q = '0;
    logic [7:0] rom1_q = '0;
    logic [8:0] last_code0 = '0;
    always @(posedge clk) begin
        if (if0.map_req) begin
            rom0_q     <= rom_fn(if0.map_code);
            last_code0 <= if0.map_code;
        end
        if (if1.map_req) rom1_q <= rom_fn(if1.map_code);
    end

    assign if0.rx_data  = rx_data;
    assign if0.rx_valid = rx_valid;
    assign if0.rx_error = rx_error;
    assign if0.ka       = ka;
    assign if0.map_hit  = rom0_q[7];
    assign if0.map_row  = rom0_q[6:3];
    assign if0.map_col  = rom0_q[2:0];
    assign if1.rx_data  = rx_data;
    assign if1.rx_valid = rx_valid;
    assign if1.rx_error = rx_error;
    assign if1.ka       = ka;
    assign if1.map_hit  = rom1_q[7];
    assign if1.map_row  = rom1_q[6:3];
    assign if1.map_col  = rom1_q[2:0];

    ps2_key_matrix #(.ROWS(ROWS), .COLS(COLS), .RST_CYCLES(RSTC), .CLR_ON_ERR(1)) u_dut0 (
        .clk(clk), .reset(reset), .bus(if0));
    ps2_key_matrix #(.ROWS(ROWS), .COLS(COLS), .RST_CYCLES(RSTC), .CLR_ON_ERR(0)) u_dut1 (
        .clk(clk), .reset(reset), .bus(if1));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: which keys are held, per engine.
    bit [ROWS-1:0][COLS-1:0] m0, m1;

    function automatic logic [COLS-1:0] exp_kd(input bit [ROWS-1:0][COLS-1:0] m,
                                              input logic [ROWS-1:0] sel);
        logic [COLS-1:0] k = '1;
        for (int r = 0; r < ROWS; r++)
            if (!sel[r]) k = k & ~m[r];
        return k;
    endfunction

    task automatic apply_key(input bit ext, input bit rel, input logic [7:0] code);
        logic [7:0] v = rom_fn({ext, code});
        int r = int'(v[6:3]);
        int c = int'(v[2:0]);
        if (v[7] && r < ROWS && c < COLS) begin
            m0[r][c] = !rel;
            m1[r][c] = !rel;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
    endtask

    task automatic send_error();
        @(posedge clk); #1;
        rx_error = 1'b1;
        @(posedge clk); #1;
        rx_error = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic key_event(input bit ext, input bit rel, input bit f0_first, input logic [7:0] code);
        if (ext && rel && f0_first) begin
            send_byte(8'hF0, 2);
            send_byte(8'hE0, 2);
        end else begin
            if (ext) send_byte(8'hE0, 2);
            if (rel) send_byte(8'hF0, 2);
        end
        send_byte(code, 2);
        apply_key(ext, rel, code);
    endtask

    task automatic check_kd(input string tag, input logic [ROWS-1:0] sel);
        ka = sel;
        #1;
        chk({tag, "_kd0"}, 32'(if0.kd), 32'(exp_kd(m0, sel)));
        chk({tag, "_kd1"}, 32'(if1.kd), 32'(exp_kd(m1, sel)));
    endtask

    task automatic send_pause(input int last_gap);
        send_byte(8'hE1, 2);
        send_byte(8'h14, 2);
        send_byte(8'h77, 2);
        send_byte(8'hE1, 2);
        send_byte(8'hF0, 2);
        send_byte(8'h14, 2);
        send_byte(8'hF0, 2);
        send_byte(8'h77, last_gap);
    endtask

    initial begin
        int hi0, hi1, ov;
        logic [7:0] code;
        rx_data  = '0;
        rx_valid = 1'b0;
        rx_error = 1'b0;
        ka       = '1;
        m0       = '0;
        m1       = '0;
        reset    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_key_reset", 32'(if0.key_reset), 32'd0);
        chk("rst_map_req", 32'(if0.map_req), 32'd0);
        chk("rst_overrun", 32'(if0.overrun), 32'd0);
        check_kd("rst_all", '0);
        reset = 1'b0;

        // Make 1C and observe the two-cycle update latency on row 1.
        ka = '1;
        ka[1] = 1'b0;
        send_byte(8'h1C, 0);
        chk("lat_c0", 32'(if0.kd), 32'h7F);
        @(posedge clk); #1;
        chk("lat_c1", 32'(if0.kd), 32'h7F);
        @(posedge clk); #1;
        chk("lat_c2", 32'(if0.kd), 32'h5F);
        apply_key(1'b0, 1'b0, 8'h1C);
        key_event(1'b0, 1'b1, 1'b0, 8'h1C);
        chk("brk_1c", 32'(if0.kd), 32'h7F);

        // Two keys in rows 0 and 1.
        key_event(1'b0, 1'b0, 1'b0, 8'h15);
        key_event(1'b0, 1'b0, 1'b0, 8'h1C);
        ka = '1; ka[0] = 1'b0; ka[1] = 1'b0; #1;
        chk("two_rows", 32'(if0.kd), 32'h1F);
        ka = '1; ka[0] = 1'b0; #1;
        chk("row0_only", 32'(if0.kd), 32'h3F);
        check_kd("two_all", '0);

        // Extended key lookup and release.
        key_event(1'b1, 1'b0, 1'b0, 8'h75);
        chk("ext_code", 32'(last_code0), 32'h175);
        ka = '1; ka[11] = 1'b0; #1;
        chk("ext_make", 32'(if0.kd), 32'h77);
        key_event(1'b1, 1'b1, 1'b0, 8'h75);
        chk("ext_brk", 32'(if0.kd), 32'h7F);

        // Overflow byte clears a pending prefix; BAT releases everything.
        send_byte(8'hE0, 2);
        send_byte(8'h00, 2);
        key_event(1'b0, 1'b0, 1'b0, 8'h33);
        check_kd("ovf_clr", '0);
        send_byte(8'hAA, 2);
        m0 = '0; m1 = '0;
        check_kd("bat", '0);

        // PAUSE/BREAK pulse length.
        send_pause(0);
        hi0 = 0; hi1 = 0;
        for (int i = 0; i < 30; i++) begin
            if (if0.key_reset) hi0++;
            if (if1.key_reset) hi1++;
            @(posedge clk); #1;
        end
        chk("pause_len0", 32'(hi0), 32'(RSTC));
        chk("pause_len1", 32'(hi1), 32'(RSTC));
        send_byte(8'hE1, 2);
        send_byte(8'h14, 2);
        send_byte(8'h12, 2);
        chk("pause_abort", 32'(if0.key_reset), 32'd0);
        key_event(1'b0, 1'b0, 1'b0, 8'h33);
        check_kd("after_abort", '0);

        // Decoder error with three keys held.
        key_event(1'b0, 1'b0, 1'b0, 8'h1C);
        key_event(1'b0, 1'b0, 1'b0, 8'h15);
        send_error();
        m0 = '0;
        check_kd("err_clr", '0);

        // Reset during the key_reset pulse and during a lookup.
        send_pause(3);
        send_byte(8'h33, 0);
        reset = 1'b1;
        #1;
        chk("mid_rst_kr0", 32'(if0.key_reset), 32'd0);
        chk("mid_rst_kr1", 32'(if1.key_reset), 32'd0);
        m0 = '0; m1 = '0;
        check_kd("mid_rst", '0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_rst_req", 32'(if0.map_req), 32'd0);
        check_kd("post_rst", '0);

        // Byte arriving during APPLY is dropped and flagged once.
        send_byte(8'h33, 0);
        @(posedge clk); #1;
        rx_data  = 8'h15;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        ov = 0;
        for (int i = 0; i < 6; i++) begin
            if (if0.overrun) ov++;
            @(posedge clk); #1;
        end
        chk("overrun_cnt", 32'(ov), 32'd1);
        apply_key(1'b0, 1'b0, 8'h33);
        check_kd("overrun_drop", '0);

        // Randomised event stream.
        for (int n = 0; n < 80; n++) begin
            int kind = $urandom_range(0, 9);
            do code = 8'($urandom_range(1, 8'hDF)); while (code == 8'hAA);
            case (kind)
                6: begin
                    send_byte(8'hAA, 2);
                    m0 = '0; m1 = '0;
                end
                7: send_byte(8'h00, 2);
                8: begin
                    send_error();
                    m0 = '0;
                end
                9: begin
                    send_byte(8'hE1, 2);
                    send_byte(8'h13, 2);
                end
                default: key_event(1'($urandom), 1'($urandom), 1'($urandom), code);
            endcase
            check_kd("rnd_all", '0);
            check_kd("rnd_sel", ROWS'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
